// File: rtl/cbx_io_tile_cfg.sv
// X-channel connection block merged with the IO pad grid, configured through a
// double-buffered serial chain that only takes effect on an explicit commit.
module cbx_io_tile_cfg #(
    parameter int CHAN_WIDTH = 30,
    parameter int NUM_IO     = 4
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  ccff_head,
    input  logic                  ccff_shift_en,
    input  logic                  ccff_commit,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    output logic                  cfg_err,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    input  logic [NUM_IO-1:0]     gfpga_pad_io_soc_in,
    input  logic                  isol_n,
    output logic [NUM_IO-1:0]     gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0]     gfpga_pad_io_soc_dir,
    output logic [NUM_IO-1:0]     top_pin_inpad
);

    localparam int SEL_W     = $clog2(2 * CHAN_WIDTH);
    localparam int FIELD_W   = SEL_W + 1;
    localparam int CHAIN_LEN = NUM_IO * FIELD_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'd0,
        ST_LOADING = 3'd1,
        ST_LOADED  = 3'd2,
        ST_OVER    = 3'd3,
        ST_ACTIVE  = 3'd4
    } cfg_state_t;

    cfg_state_t             state_r;
    cfg_state_t             state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_s;
    logic [CHAIN_LEN-1:0]   shadow_r;
    logic [CHAIN_LEN-1:0]   active_r;
    logic                   cfg_done_r;
    logic                   cfg_err_r;
    logic                   commit_ok_s;
    logic                   commit_rej_s;

    // A commit only lands when the chain holds exactly one full load and no shift competes.
    assign commit_ok_s  = ccff_commit & ~ccff_shift_en & (state_r == ST_LOADED);
    assign commit_rej_s = ccff_commit & ~commit_ok_s;

    // State, counter, shadow/active configuration and status flags.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_r    <= ST_EMPTY;
            cnt_r      <= {CNT_W{1'b0}};
            shadow_r   <= {CHAIN_LEN{1'b0}};
            active_r   <= {CHAIN_LEN{1'b0}};
            cfg_done_r <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cfg_done_r <= (state_s == ST_ACTIVE);
            if (ccff_shift_en) begin
                shadow_r <= {shadow_r[CHAIN_LEN-2:0], ccff_head};
            end
            if (commit_ok_s) begin
                active_r <= shadow_r;
            end
            if (commit_rej_s) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    // Next-state and bit-count logic of the configuration FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_EMPTY: begin
                if (ccff_shift_en) begin
                    state_s = ST_LOADING;
                    cnt_s   = CNT_W'(1);
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_LOADING: begin
                if (ccff_shift_en) begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if ((cnt_r + CNT_W'(1)) == CNT_W'(CHAIN_LEN)) begin
                        state_s = ST_LOADED;
                    end else begin
                        state_s = ST_LOADING;
                    end
                end else begin
                    state_s = ST_LOADING;
                end
            end
            ST_LOADED: begin
                if (ccff_shift_en) begin
                    state_s = ST_OVER;
                    cnt_s   = CNT_W'(CHAIN_LEN + 1);
                end else if (ccff_commit) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_LOADED;
                end
            end
            ST_OVER: begin
                if (ccff_shift_en) begin
                    cnt_s = CNT_W'(CHAIN_LEN + 1);
                end else begin
                    cnt_s = cnt_r;
                end
                state_s = ST_OVER;
            end
            ST_ACTIVE: begin
                if (ccff_shift_en) begin
                    state_s = ST_LOADING;
                    cnt_s   = CNT_W'(1);
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_EMPTY;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign ccff_tail       = shadow_r[CHAIN_LEN-1];
    assign cfg_done        = cfg_done_r;
    assign cfg_err         = cfg_err_r;
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    // Pad datapath: per-pad track mux, direction and isolation gating.
    always_comb begin : pad_logic
        logic [SEL_W-1:0] sel_v;
        logic             oe_v;
        logic             src_v;
        logic             en_v;
        gfpga_pad_io_soc_out = {NUM_IO{1'b0}};
        gfpga_pad_io_soc_dir = {NUM_IO{1'b1}};
        top_pin_inpad        = {NUM_IO{1'b0}};
        sel_v = {SEL_W{1'b0}};
        oe_v  = 1'b0;
        src_v = 1'b0;
        en_v  = 1'b0;
        for (int i = 0; i < NUM_IO; i++) begin
            sel_v = active_r[i*FIELD_W+1 +: SEL_W];
            oe_v  = active_r[i*FIELD_W];
            src_v = 1'b0;
            // Out-of-range selects match no track and leave the source at 0.
            for (int j = 0; j < CHAN_WIDTH; j++) begin
                if (sel_v == SEL_W'(j)) begin
                    src_v = chanx_left_in[j];
                end else if (sel_v == SEL_W'(j + CHAN_WIDTH)) begin
                    src_v = chanx_right_in[j];
                end else begin
                    src_v = src_v;
                end
            end
            en_v = isol_n & oe_v;
            gfpga_pad_io_soc_out[i] = en_v & src_v;
            gfpga_pad_io_soc_dir[i] = ~en_v;
            top_pin_inpad[i]        = isol_n & ~oe_v & gfpga_pad_io_soc_in[i];
        end
    end

endmodule

// File: tb/tb_cbx_io_tile_cfg.sv
// Directed bench for cbx_io_tile_cfg: datapath vector table plus hand-written
// configuration-chain sequences.
module tb_cbx_io_tile_cfg;

    localparam int CW  = 30;
    localparam int NIO = 4;
    localparam int CL  = 28;

    logic            prog_clk = 1'b0;
    logic            prog_reset;
    logic            ccff_head;
    logic            ccff_shift_en;
    logic            ccff_commit;
    logic            ccff_tail;
    logic            cfg_done;
    logic            cfg_err;
    logic [CW-1:0]   chanx_left_in;
    logic [CW-1:0]   chanx_right_in;
    logic [CW-1:0]   chanx_left_out;
    logic [CW-1:0]   chanx_right_out;
    logic [NIO-1:0]  gfpga_pad_io_soc_in;
    logic            isol_n;
    logic [NIO-1:0]  gfpga_pad_io_soc_out;
    logic [NIO-1:0]  gfpga_pad_io_soc_dir;
    logic [NIO-1:0]  top_pin_inpad;

    int n_checks = 0;
    int n_fail   = 0;

    cbx_io_tile_cfg #(.CHAN_WIDTH(CW), .NUM_IO(NIO)) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .ccff_head            (ccff_head),
        .ccff_shift_en        (ccff_shift_en),
        .ccff_commit          (ccff_commit),
        .ccff_tail            (ccff_tail),
        .cfg_done             (cfg_done),
        .cfg_err              (cfg_err),
        .chanx_left_in        (chanx_left_in),
        .chanx_right_in       (chanx_right_in),
        .chanx_left_out       (chanx_left_out),
        .chanx_right_out      (chanx_right_out),
        .gfpga_pad_io_soc_in  (gfpga_pad_io_soc_in),
        .isol_n               (isol_n),
        .gfpga_pad_io_soc_out (gfpga_pad_io_soc_out),
        .gfpga_pad_io_soc_dir (gfpga_pad_io_soc_dir),
        .top_pin_inpad        (top_pin_inpad)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic          isol;
        logic [CW-1:0] left;
        logic [CW-1:0] right;
        logic [3:0]    pin;
        logic [3:0]    exp_out;
        logic [3:0]    exp_dir;
        logic [3:0]    exp_inpad;
    } dp_vec_t;

    dp_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CL-1:0] mk_cfg(input logic [6:0] f0, input logic [6:0] f1,
                                             input logic [6:0] f2, input logic [6:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
    endtask

    task automatic shift_bit(input logic b, input logic with_commit);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        ccff_commit   = with_commit;
        tick();
        ccff_shift_en = 1'b0;
        ccff_commit   = 1'b0;
        ccff_head     = 1'b0;
    endtask

    // MSB of the word goes in first so the word lands in the shadow as written.
    task automatic shift_word(input logic [CL-1:0] w, input int n, input logic commit_last);
        for (int k = 0; k < n; k++) begin
            shift_bit(w[CL-1-(k % CL)], commit_last && (k == n - 1));
        end
    endtask

    task automatic do_commit();
        ccff_commit = 1'b1;
        tick();
        ccff_commit = 1'b0;
    endtask

    task automatic drive_dp(input logic isol, input logic [CW-1:0] l,
                            input logic [CW-1:0] r, input logic [3:0] p);
        isol_n              = isol;
        chanx_left_in       = l;
        chanx_right_in      = r;
        gfpga_pad_io_soc_in = p;
        #1;
    endtask

    task automatic run_vec(input string tag, input int i);
        drive_dp(vecs[i].isol, vecs[i].left, vecs[i].right, vecs[i].pin);
        check({tag, "_out"},   64'(gfpga_pad_io_soc_out), 64'(vecs[i].exp_out));
        check({tag, "_dir"},   64'(gfpga_pad_io_soc_dir), 64'(vecs[i].exp_dir));
        check({tag, "_inpad"}, 64'(top_pin_inpad),        64'(vecs[i].exp_inpad));
    endtask

    initial begin
        logic [CL-1:0] cfg_a;
        logic [CL-1:0] cfg_b;
        logic [CL-1:0] pat;
        logic [CW-1:0] ones;
        logic [2*CL-1:0] stream;

        ones  = {CW{1'b1}};
        // A: pad0 sel=5 oe=1, other pads inputs.
        cfg_a = mk_cfg({6'd5, 1'b1}, 7'd0, 7'd0, 7'd0);
        // B: pad0 sel=5 oe=1, pad1 sel=12 input, pad2 sel=45 oe=1, pad3 sel=63 oe=1.
        cfg_b = mk_cfg({6'd5, 1'b1}, {6'd12, 1'b0}, {6'd45, 1'b1}, {6'd63, 1'b1});

        // Expected pad behaviour under config B.
        vecs[0] = '{1'b1, 30'd1 << 5, 30'd0,       4'b1111, 4'b0001, 4'b0010, 4'b0010};
        vecs[1] = '{1'b1, 30'd0,      30'd1 << 15, 4'b0000, 4'b0100, 4'b0010, 4'b0000};
        vecs[2] = '{1'b1, ones,       ones,        4'b0101, 4'b0101, 4'b0010, 4'b0000};
        vecs[3] = '{1'b0, ones,       ones,        4'b1111, 4'b0000, 4'b1111, 4'b0000};
        vecs[4] = '{1'b1, ~(30'd1 << 5), ~(30'd1 << 15), 4'b0010, 4'b0000, 4'b0010, 4'b0010};
        vecs[5] = '{1'b1, 30'd1 << 4, 30'd1 << 14, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

        prog_reset    = 1'b1;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_commit   = 1'b0;
        drive_dp(1'b1, '0, '0, 4'b0000);
        tick();
        tick();
        prog_reset = 1'b0;

        // Reset state.
        check("rst_dir",   64'(gfpga_pad_io_soc_dir), 64'(4'b1111));
        check("rst_out",   64'(gfpga_pad_io_soc_out), 64'(4'b0000));
        check("rst_inpad", 64'(top_pin_inpad),        64'(4'b0000));
        check("rst_done",  64'(cfg_done), 64'(1'b0));
        check("rst_err",   64'(cfg_err),  64'(1'b0));
        check("rst_tail",  64'(ccff_tail), 64'(1'b0));
        drive_dp(1'b1, '0, '0, 4'b1010);
        check("rst_inpad_pass", 64'(top_pin_inpad), 64'(4'b1010));

        // Config A: full load, commit.
        drive_dp(1'b1, 30'd1 << 5, '0, 4'b0000);
        shift_word(cfg_a, CL, 1'b0);
        check("a_done_pre", 64'(cfg_done), 64'(1'b0));
        check("a_out_pre",  64'(gfpga_pad_io_soc_out), 64'(4'b0000));
        do_commit();
        check("a_done",  64'(cfg_done), 64'(1'b1));
        check("a_err",   64'(cfg_err),  64'(1'b0));
        check("a_out",   64'(gfpga_pad_io_soc_out), 64'(4'b0001));
        check("a_dir",   64'(gfpga_pad_io_soc_dir), 64'(4'b1110));

        // Config B: reload from ACTIVE, then the vector table.
        shift_word(cfg_b, CL, 1'b0);
        do_commit();
        check("b_done", 64'(cfg_done), 64'(1'b1));
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), i);
            check($sformatf("vec%0d_lpass", i), 64'(chanx_left_out),  64'(vecs[i].right));
            check($sformatf("vec%0d_rpass", i), 64'(chanx_right_out), 64'(vecs[i].left));
        end

        // Short load: commit rejected, active config B retained.
        shift_word(cfg_a, CL - 1, 1'b0);
        do_commit();
        check("short_err",  64'(cfg_err),  64'(1'b1));
        check("short_done", 64'(cfg_done), 64'(1'b0));
        run_vec("short_keep", 1);

        // Over-length load after reset: commit rejected.
        do_reset();
        check("rst2_err", 64'(cfg_err), 64'(1'b0));
        shift_word(cfg_b, CL + 1, 1'b0);
        do_commit();
        check("over_err",  64'(cfg_err),  64'(1'b1));
        check("over_done", 64'(cfg_done), 64'(1'b0));
        run_vec("over_keep0", 3);

        // Chain latency: tail repeats head CL shifts later.
        do_reset();
        pat    = 28'hB3C_5A69;
        stream = {pat, ~pat};
        for (int m = 1; m <= 2 * CL; m++) begin
            shift_bit(stream[2*CL-m], 1'b0);
            if (m < CL) begin
                check($sformatf("tail_zero%0d", m), 64'(ccff_tail), 64'(1'b0));
            end else begin
                check($sformatf("tail%0d", m), 64'(ccff_tail), 64'(stream[2*CL-1-(m-CL)]));
            end
        end

        // Reload from ACTIVE with commit coinciding with the last shift.
        do_reset();
        shift_word(cfg_b, CL, 1'b0);
        do_commit();
        check("rl_done0", 64'(cfg_done), 64'(1'b1));
        shift_bit(cfg_a[CL-1], 1'b0);
        check("rl_done_drop", 64'(cfg_done), 64'(1'b0));
        run_vec("rl_old1", 1);
        for (int k = 1; k < CL; k++) begin
            shift_bit(cfg_a[CL-1-k], k == CL - 1);
        end
        check("rl_err",  64'(cfg_err),  64'(1'b1));
        check("rl_done", 64'(cfg_done), 64'(1'b0));
        run_vec("rl_old2", 1);
        do_commit();
        check("rl_done2", 64'(cfg_done), 64'(1'b1));
        drive_dp(1'b1, 30'd1 << 5, 30'd1 << 15, 4'b0000);
        check("rl_new_out", 64'(gfpga_pad_io_soc_out), 64'(4'b0001));
        check("rl_new_dir", 64'(gfpga_pad_io_soc_dir), 64'(4'b1110));

        // Reset mid-load discards everything, including the active config.
        shift_word(cfg_b, 10, 1'b0);
        do_reset();
        check("mid_dir",  64'(gfpga_pad_io_soc_dir), 64'(4'b1111));
        check("mid_out",  64'(gfpga_pad_io_soc_out), 64'(4'b0000));
        check("mid_done", 64'(cfg_done), 64'(1'b0));
        check("mid_err0", 64'(cfg_err),  64'(1'b0));
        do_commit();
        check("mid_err",  64'(cfg_err),  64'(1'b1));
        check("mid_done2", 64'(cfg_done), 64'(1'b0));
        shift_word(cfg_a, CL, 1'b0);
        do_commit();
        check("fresh_done", 64'(cfg_done), 64'(1'b1));
        check("fresh_out",  64'(gfpga_pad_io_soc_out), 64'(4'b0001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cbx_io_tile_cfg.md
# cbx_io_tile_cfg

Parametrised successor to the fixed 4-pad bottom IO tile: one block that merges the X-channel connection block and the IO grid for any channel width and pad count. It adds a double-buffered configuration chain, so shifted bits only take effect on an explicit commit. It also adds a bit counter that detects short and over-length loads. It sits on the IO ring between the routing channel and the SoC pad interface.

## Interface
- CHAN_WIDTH, 30, tracks per channel direction.
- NUM_IO, 4, pad subtiles in the tile.
- SEL_W, $clog2(2*CHAN_WIDTH) (6 at default), width of the per-pad source select.
- CHAIN_LEN, NUM_IO*(SEL_W+1) (28 at default), configuration bits in the chain; derived, not overridden.

Ports:
- prog_clk  in  1  the only clock. All state updates on the rising edge.
- prog_reset  in  1  reset. Synchronous and active-high.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift one bit this cycle.
- ccff_commit  in  1  request to copy the shadow register into the active config.
- ccff_tail  out  1  serial data out; always shadow[CHAIN_LEN-1].
- cfg_done  out  1  active config is valid and matches the last full load.
- cfg_err  out  1  sticky error flag.
- chanx_left_in, chanx_right_in  in  CHAN_WIDTH  channel tracks.
- chanx_left_out, chanx_right_out  out  CHAN_WIDTH  pass-through: left_out = right_in, right_out = left_in.
- gfpga_pad_io_soc_in  in  NUM_IO  pad input.
- isol_n  in  1  active-low isolation.
- gfpga_pad_io_soc_out  out  NUM_IO  pad output data.
- gfpga_pad_io_soc_dir  out  NUM_IO  pad direction; 1 = input.
- top_pin_inpad  out  NUM_IO  pad-to-fabric data.

## Operation
Shadow register layout:
- Pad i owns field shadow[i*(SEL_W+1) +: SEL_W+1].
- Field bit 0 = oe. Field bits [SEL_W:1] = sel.

Shifting:
- On each shift cycle, shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}.
- The first bit shifted in ends up in the MSB; the last bit shifted in is pad 0's oe.

Bit counter `cnt` (width $clog2(CHAIN_LEN+2)):
- Increments on each shift.
- Saturates at CHAIN_LEN+1.

Config FSM:
- EMPTY: on shift -> LOADING, cnt=1.
- LOADING: on shift, cnt++. When cnt reaches CHAIN_LEN -> LOADED.
- LOADED: on shift -> OVER (cnt = CHAIN_LEN+1). On commit (without shift) -> ACTIVE: active <= shadow, cfg_done=1.
- OVER: shifts keep cnt saturated.
- ACTIVE: on shift -> LOADING, cnt=1, cfg_done=0, active register retained.

Errors:
- A commit in any state other than LOADED sets cfg_err; the active register is unchanged.
- Commit and shift in the same cycle: the shift is performed, the commit is rejected, cfg_err is set.
- cfg_err is cleared only by prog_reset.

Datapath (combinational from active config):
- src(i) = chanx_left_in[sel_i] if sel_i < CHAN_WIDTH.
- src(i) = chanx_right_in[sel_i-CHAN_WIDTH] if sel_i < 2*CHAN_WIDTH.
- src(i) = 0 otherwise (out-of-range select).
- gfpga_pad_io_soc_out[i] = isol_n & oe_i & src(i).
- gfpga_pad_io_soc_dir[i] = ~(isol_n & oe_i).
- top_pin_inpad[i] = isol_n & ~oe_i & gfpga_pad_io_soc_in[i].

## Timing
Reset (prog_reset high at an edge):
- shadow=0, active=0, cnt=0, state EMPTY.
- cfg_done=0, cfg_err=0, ccff_tail=0.
- With active=0, every pad is an input: dir=1, soc_out=0.
- A reset mid-load or mid-commit discards all progress, and the active register also returns to 0.

Latency:
- ccff_tail follows the same edge that shifts; chain latency is CHAIN_LEN cycles head-to-tail.
- An accepted commit at edge k: active register, cfg_done and pad outputs all change after edge k.
- cfg_err is set at the rejecting edge.
- Routing pass-through and pad logic add zero cycles.

## Test plan
- Reset, then idle: dir=4'b1111, soc_out=0, cfg_done=0, cfg_err=0, top_pin_inpad=0.
- Shift 28 bits with pad0 sel=5, oe=1 and pads 1-3 oe=0; commit; drive chanx_left_in[5]=1 with isol_n=1 -> soc_out[0]=1, dir[0]=0, cfg_done=1 on the cycle after the commit edge.
- Pad2 sel=45, oe=1 -> soc_out[2] follows chanx_right_in[15]. Pad3 sel=63 -> soc_out[3]=0. Pull isol_n low -> all soc_out=0, dir=1, top_pin_inpad=0.
- Shift 27 bits then commit -> cfg_err=1, active unchanged. Shift 29 bits then commit -> cfg_err=1. Push a 28-bit pattern through -> ccff_tail reproduces ccff_head delayed 28 cycles.
- In ACTIVE, start a new load -> cfg_done drops on the first shift while the old pad behaviour persists until the second commit. Assert commit together with the 28th shift -> cfg_err=1, state LOADED.
- Assert prog_reset after 10 shifts -> cnt=0; a subsequent commit is rejected; after a fresh 28-bit load and commit, cfg_done=1.
